// File: rtl/step_ctrl_pkg.sv
// Shared types and encodings for the step controller.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GUARD = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_INIT = 2'b01;
  localparam logic [1:0] CAUSE_DONE = 2'b10;
  localparam logic [1:0] CAUSE_TMO  = 2'b11;

  // Largest of four integers, used to size the shared cycle counter.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/busy_aggregator.sv
// Reduces per-channel busy flags to one aggregate busy and flags its falling
// edge as a completion event.
module busy_aggregator #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] busy,
  input  logic [NCH-1:0] chan_en,
  input  logic           mode_all,
  output logic           agg,
  output logic           agg_q,
  output logic           done_evt
);

  // mode_all=1: busy while any enabled channel is busy (step when all done).
  // mode_all=0: busy only while every enabled channel is busy (step when any done).
  always_comb begin
    agg = 1'b0;
    if (chan_en == '0) begin
      agg = 1'b0;
    end else if (mode_all) begin
      agg = |(busy & chan_en);
    end else begin
      agg = &(busy | ~chan_en);
    end
  end

  // Previous aggregate; resets high so a quiet bus after reset reads as a fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) agg_q <= 1'b1;
    else        agg_q <= agg;
  end

  assign done_evt = agg_q & ~agg;

endmodule

// File: rtl/step_controller.sv
// Step pulse generator: an initial step after reset, then one step per
// completion of the enabled busy channels, with an optional timeout fallback.
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PULSE_W  = 6,
  parameter int GUARD_W  = 2,
  parameter int INIT_DLY = 2,
  parameter int TW       = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] busy,
  input  logic [NCH-1:0] chan_en,
  input  logic           mode_all,
  input  logic [TW-1:0]  timeout_cycles,
  output logic           step,
  output logic [1:0]     cause,
  output logic [15:0]    timeout_count,
  output logic [1:0]     state_dbg
);

  localparam int CMAX = max4(PULSE_W, GUARD_W, INIT_DLY, 2 ** TW);
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INIT_LAST  = CW'(INIT_DLY - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_W - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [TW-1:0]   tmo_q, tmo_nx;
  logic [CW-1:0]   tmo_last;
  logic            pending, pending_nx;
  logic            step_nx;
  logic [1:0]      cause_nx;
  logic [15:0]     tcnt_nx;
  logic            agg, agg_q, done_evt;

  busy_aggregator #(.NCH(NCH)) u_agg (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy),
    .chan_en  (chan_en),
    .mode_all (mode_all),
    .agg      (agg),
    .agg_q    (agg_q),
    .done_evt (done_evt)
  );

  assign tmo_last  = CW'(tmo_q) - CW'(1);
  assign state_dbg = state;

  // State and output registers; step/cause drop immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_INIT;
      cnt           <= '0;
      tmo_q         <= '0;
      pending       <= 1'b0;
      step          <= 1'b0;
      cause         <= CAUSE_NONE;
      timeout_count <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      tmo_q         <= tmo_nx;
      pending       <= pending_nx;
      step          <= step_nx;
      cause         <= cause_nx;
      timeout_count <= tcnt_nx;
    end
  end

  // Next-state logic; one shared counter times every state.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    tmo_nx     = tmo_q;
    pending_nx = pending;
    step_nx    = step;
    cause_nx   = cause;
    tcnt_nx    = timeout_count;
    case (state)
      ST_INIT: begin
        if (cnt == INIT_LAST) begin
          state_nx = ST_PULSE;
          cnt_nx   = '0;
          step_nx  = 1'b1;
          cause_nx = CAUSE_INIT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_PULSE: begin
        // Completion events here are deliberately dropped.
        if (cnt == PULSE_LAST) begin
          state_nx = ST_GUARD;
          cnt_nx   = '0;
          step_nx  = 1'b0;
          cause_nx = CAUSE_NONE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_GUARD: begin
        if (done_evt) pending_nx = 1'b1;
        if (cnt == GUARD_LAST) begin
          state_nx = ST_WAIT;
          cnt_nx   = '0;
          tmo_nx   = timeout_cycles;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_WAIT: begin
        // Completion wins over a timeout expiring on the same edge.
        if (done_evt || pending) begin
          state_nx   = ST_PULSE;
          cnt_nx     = '0;
          step_nx    = 1'b1;
          cause_nx   = CAUSE_DONE;
          pending_nx = 1'b0;
        end else if ((tmo_q != '0) && (cnt == tmo_last)) begin
          state_nx = ST_PULSE;
          cnt_nx   = '0;
          step_nx  = 1'b1;
          cause_nx = CAUSE_TMO;
          if (timeout_count != 16'hFFFF) tcnt_nx = timeout_count + 16'd1;
        end else if (tmo_q != '0) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_INIT;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller: expected pulses are queued as stimulus
// is driven and checked by a monitor when the step output rises.
module tb_step_controller;
  import step_ctrl_pkg::*;

  localparam int NCH     = 4;
  localparam int PULSE_W = 6;
  localparam int GUARD_W = 2;
  localparam int TW      = 8;
  localparam int EW      = 50;   // {cycle[31:0], cause[1:0], timeout_count[15:0]}

  logic           clk;
  logic           reset;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] chan_en;
  logic           mode_all;
  logic [TW-1:0]  timeout_cycles;
  logic           step;
  logic [1:0]     cause;
  logic [15:0]    timeout_count;
  logic [1:0]     state_dbg;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  logic step_d = 1'b0;
  int hi_cnt   = 0;

  step_controller #(
    .NCH(NCH), .PULSE_W(PULSE_W), .GUARD_W(GUARD_W), .INIT_DLY(2), .TW(TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .busy           (busy),
    .chan_en        (chan_en),
    .mode_all       (mode_all),
    .timeout_cycles (timeout_cycles),
    .step           (step),
    .cause          (cause),
    .timeout_count  (timeout_count),
    .state_dbg      (state_dbg)
  );

  // Clock and cycle index (cyc==n after the n-th rising edge).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input logic [1:0] ca, input logic [15:0] t);
    logic [31:0] cv;
    cv = c;
    exp_q.push_back({cv, ca, t});
  endtask

  // Advance to just after rising edge c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: checks each step rise against the queue, and pulse width at each fall.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (step && !step_d) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_step cyc=%0d observed=1 expected=0", cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert (cyc === int'(e[49:18])) else begin
          n_err++;
          $error("FAIL step_cycle observed=%0d expected=%0d", cyc, e[49:18]);
        end
        n_checks++;
        assert (cause === e[17:16]) else begin
          n_err++;
          $error("FAIL step_cause cyc=%0d observed=%0b expected=%0b", cyc, cause, e[17:16]);
        end
        n_checks++;
        assert (timeout_count === e[15:0]) else begin
          n_err++;
          $error("FAIL tmo_count cyc=%0d observed=%0d expected=%0d", cyc, timeout_count, e[15:0]);
        end
      end
      hi_cnt = 1;
    end else if (step) begin
      hi_cnt++;
    end
    if (!step && step_d && reset) begin
      n_checks++;
      assert (hi_cnt == PULSE_W) else begin
        n_err++;
        $error("FAIL pulse_width cyc=%0d observed=%0d expected=%0d", cyc, hi_cnt, PULSE_W);
      end
      n_checks++;
      assert (cause === CAUSE_NONE) else begin
        n_err++;
        $error("FAIL cause_idle cyc=%0d observed=%0b expected=00", cyc, cause);
      end
    end
    step_d = step;
  end

  // Directed sequence.
  initial begin
    int s, w;
    reset          = 1'b0;
    busy           = '0;
    chan_en        = 4'hF;
    mode_all       = 1'b1;
    timeout_cycles = '0;

    // Reset values.
    goto(3);
    n_checks++;
    assert (step === 1'b0 && cause === CAUSE_NONE && timeout_count === 16'd0 && state_dbg === 2'd0) else begin
      n_err++;
      $error("FAIL reset_vals observed=%b/%b/%0d/%0d expected=0/00/0/0", step, cause, timeout_count, state_dbg);
    end

    // Initial step two cycles after release.
    goto(4);
    reset = 1'b1;
    s = 4 + 2;
    push_exp(s, CAUSE_INIT, 16'd0);

    // All-done mode: busy F -> 0 in WAIT.
    goto(s + 1); busy = 4'hF;
    w = s + PULSE_W + GUARD_W;
    goto(w + 3); busy = 4'h0;
    s = w + 4;
    push_exp(s, CAUSE_DONE, 16'd0);

    // Any-done mode: one channel finishing is enough.
    goto(s + 1); busy = 4'hF; mode_all = 1'b0;
    w = s + PULSE_W + GUARD_W;
    goto(w + 2); busy = 4'hE;
    s = w + 3;
    push_exp(s, CAUSE_DONE, 16'd0);

    // All-done mode with the same stimulus: no step until the last channel.
    goto(s + 1); busy = 4'hF; mode_all = 1'b1;
    w = s + PULSE_W + GUARD_W;
    goto(w + 2); busy = 4'hE;
    goto(w + 6);
    n_checks++;
    assert (step === 1'b0) else begin
      n_err++;
      $error("FAIL all_mode_partial observed=%b expected=0", step);
    end
    goto(w + 8); busy = 4'h0;
    s = w + 9;
    push_exp(s, CAUSE_DONE, 16'd0);

    // Timeouts of 10 cycles, then a mid-WAIT change that must not apply early.
    goto(s + 1); busy = 4'hF; timeout_cycles = 8'd10;
    w = s + PULSE_W + GUARD_W;
    s = w + 10;
    push_exp(s, CAUSE_TMO, 16'd1);
    w = s + PULSE_W + GUARD_W;
    goto(w + 3); timeout_cycles = 8'd3;
    s = w + 10;
    push_exp(s, CAUSE_TMO, 16'd2);
    w = s + PULSE_W + GUARD_W;
    s = w + 3;
    push_exp(s, CAUSE_TMO, 16'd3);

    // Completion on the timeout-expiry edge: completion wins.
    w = s + PULSE_W + GUARD_W;
    goto(w + 2); busy = 4'h0;
    s = w + 3;
    push_exp(s, CAUSE_DONE, 16'd3);

    // Completion during GUARD is held and fires on the first WAIT edge.
    goto(s + 1); busy = 4'hF; timeout_cycles = 8'd0;
    goto(s + PULSE_W); busy = 4'h0;
    s = s + PULSE_W + GUARD_W + 1;
    push_exp(s, CAUSE_DONE, 16'd3);

    // Completion during PULSE is dropped; timeout 0 then waits forever.
    goto(s + 1); busy = 4'hF;
    goto(s + 2); busy = 4'h0;
    w = s + PULSE_W + GUARD_W;
    goto(w + 30);
    n_checks++;
    assert (step === 1'b0) else begin
      n_err++;
      $error("FAIL wait_forever observed=%b expected=0", step);
    end
    busy = 4'hF;

    // Disabling every channel drops agg and counts as a completion.
    goto(w + 31); chan_en = 4'h0;
    s = w + 32;
    push_exp(s, CAUSE_DONE, 16'd3);

    // Reset mid-pulse drops step at once; the sequence restarts.
    goto(s + 1); chan_en = 4'hF;
    goto(s + 3); reset = 1'b0;
    #1;
    n_checks++;
    assert (step === 1'b0 && cause === CAUSE_NONE && timeout_count === 16'd0) else begin
      n_err++;
      $error("FAIL async_reset observed=%b/%b/%0d expected=0/00/0", step, cause, timeout_count);
    end
    goto(s + 6); reset = 1'b1;
    s = s + 6 + 2;
    push_exp(s, CAUSE_INIT, 16'd0);

    goto(s + PULSE_W + 6);
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_err++;
      $error("FAIL missing_steps observed=%0d pending expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
